// File: rtl/display_mux_7seg_if.sv
// display_mux_7seg_if
//   Groups the display-multiplexer data and display pins into one bundle.
//   The master side drives the display clock, value and masks; the slave
//   side (display_mux_7seg) drives the anodes, segments, dp and frame pulse.
//
//   i_clk_disp    divided display clock (sampled as data)
//   i_value       four hex nibbles, [3:0] = digit 0 (rightmost)
//   i_dp_in       decimal point request per digit, 1 = lit
//   i_blank_in    per-digit blank, 1 = digit dark
//   o_an          digit anodes
//   o_seg         segments {g,f,e,d,c,b,a}
//   o_dp          decimal point for the active digit
//   o_frame_done  one-cycle pulse when a new frame snapshot is taken
interface display_mux_7seg_if;
  logic        i_clk_disp;
  logic [15:0] i_value;
  logic [3:0]  i_dp_in;
  logic [3:0]  i_blank_in;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame_done;

  modport master (
    output i_clk_disp, i_value, i_dp_in, i_blank_in,
    input  o_an, o_seg, o_dp, o_frame_done
  );

  modport slave (
    input  i_clk_disp, i_value, i_dp_in, i_blank_in,
    output o_an, o_seg, o_dp, o_frame_done
  );
endinterface

// File: rtl/display_mux_7seg.sv
// display_mux_7seg
//   Drives a 4-digit multiplexed 7-segment display. Each rising edge of the
//   divided display clock advances to the next digit. The value, dp mask and
//   blank mask are snapshotted when the digit index wraps 3->0, so a frame
//   never shows a mix of old and new data.
//
//   clk    system clock (only clock in the block)
//   rst_n  asynchronous active-low reset
//   bus    display_mux_7seg_if.slave: clk_disp/value/dp/blank in,
//          an/seg/dp/frame_done out
//
//   LZ_BLANK   1 = suppress leading zeros on digits 3..1
//   ACTIVE_LOW 1 = an/seg/dp active-low, 0 = active-high
module display_mux_7seg #(
  parameter bit LZ_BLANK   = 1'b0,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  display_mux_7seg_if.slave bus
);

  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic        r_s1, r_s2, r_s3;
  logic [1:0]  r_idx;
  logic [15:0] r_val;
  logic [3:0]  r_dp_m;
  logic [3:0]  r_blank_m;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;
  logic        r_frame_done;

  logic        w_tick;
  logic        w_wrap;
  logic [1:0]  w_idx_nxt;
  logic [15:0] w_val;
  logic [3:0]  w_dp_m;
  logic [3:0]  w_blank_m;
  logic [3:0]  w_nib;
  logic        w_lz;
  logic        w_blank;
  logic [3:0]  w_an;
  logic [6:0]  w_seg;
  logic        w_dp;

  // Active-low hex decode, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] f_seg_al(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'b1000000;
      4'h1: pat = 7'b1111001;
      4'h2: pat = 7'b0100100;
      4'h3: pat = 7'b0110000;
      4'h4: pat = 7'b0011001;
      4'h5: pat = 7'b0010010;
      4'h6: pat = 7'b0000010;
      4'h7: pat = 7'b1111000;
      4'h8: pat = 7'b0000000;
      4'h9: pat = 7'b0010000;
      4'hA: pat = 7'b0001000;
      4'hB: pat = 7'b0000011;
      4'hC: pat = 7'b1000110;
      4'hD: pat = 7'b0100001;
      4'hE: pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

  // clk_disp is only ever sampled as data: two sync flops plus an edge flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.i_clk_disp;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_tick = r_s2 & ~r_s3;

  always_comb begin
    w_wrap    = (r_idx == 2'd3);
    w_idx_nxt = r_idx + 2'd1;
    // On the wrap tick, digit 0 must already use the data being captured.
    w_val     = w_wrap ? bus.i_value    : r_val;
    w_dp_m    = w_wrap ? bus.i_dp_in    : r_dp_m;
    w_blank_m = w_wrap ? bus.i_blank_in : r_blank_m;

    w_nib = w_val[3:0];
    w_lz  = 1'b0;
    case (w_idx_nxt)
      2'd0: begin w_nib = w_val[3:0];   w_lz = 1'b0;                   end
      2'd1: begin w_nib = w_val[7:4];   w_lz = (w_val[15:4]  == 12'h0); end
      2'd2: begin w_nib = w_val[11:8];  w_lz = (w_val[15:8]  == 8'h0);  end
      default: begin w_nib = w_val[15:12]; w_lz = (w_val[15:12] == 4'h0); end
    endcase

    w_blank = w_blank_m[w_idx_nxt] | (LZ_BLANK & w_lz);

    // Build active-high levels, then apply board polarity once.
    w_an  = w_blank ? 4'h0  : (4'b0001 << w_idx_nxt);
    w_seg = w_blank ? 7'h00 : ~f_seg_al(w_nib);
    w_dp  = w_blank ? 1'b0  : w_dp_m[w_idx_nxt];
    if (ACTIVE_LOW) begin
      w_an  = ~w_an;
      w_seg = ~w_seg;
      w_dp  = ~w_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= 2'd3;
      r_val        <= 16'h0;
      r_dp_m       <= 4'h0;
      r_blank_m    <= 4'h0;
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_tick) begin
        r_idx <= w_idx_nxt;
        r_an  <= w_an;
        r_seg <= w_seg;
        r_dp  <= w_dp;
        if (w_wrap) begin
          r_val        <= bus.i_value;
          r_dp_m       <= bus.i_dp_in;
          r_blank_m    <= bus.i_blank_in;
          r_frame_done <= 1'b1;
        end
      end
    end
  end

  assign bus.o_an         = r_an;
  assign bus.o_seg        = r_seg;
  assign bus.o_dp         = r_dp;
  assign bus.o_frame_done = r_frame_done;

endmodule
